// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: word widths, the reset PC, the HALT
// instruction encoding (also used by the decoder) and the fetch state enum.
package cpu_pkg;

  localparam int unsigned PcW  = 4;
  localparam int unsigned InsW = 9;

  localparam logic [PcW-1:0]  ResetPc = 4'd0;
  localparam logic [InsW-1:0] HaltIns = 9'b011000000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } fetch_state_e;

  function automatic logic is_halt(input logic [InsW-1:0] ins);
    return ins == HaltIns;
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bus between the fetch sequencer, ins_mem and the execute datapath.
//   start     : leave IDLE/HALT and begin fetching at the reset PC
//   pc        : address to ins_mem
//   mem_ins   : ins_mem output for pc (combinational)
//   ins       : latched instruction for the datapath
//   ins_valid : ins awaiting execution
//   exec_done : datapath finished ins
//   br_taken  : with exec_done, next pc is br_tgt
//   br_tgt    : branch target
//   halted    : sequencer stopped on the HALT instruction
//   step      : single-step enable (only when SINGLE_STEP_EN is defined)
// master = sequencer side, slave = memory/datapath side.
interface fetch_seq_if;
  import cpu_pkg::*;

  logic            start;
  logic [PcW-1:0]  pc;
  logic [InsW-1:0] mem_ins;
  logic [InsW-1:0] ins;
  logic            ins_valid;
  logic            exec_done;
  logic            br_taken;
  logic [PcW-1:0]  br_tgt;
  logic            halted;
`ifdef SINGLE_STEP_EN
  logic            step;

  modport master (
    input  start, mem_ins, exec_done, br_taken, br_tgt, step,
    output pc, ins, ins_valid, halted
  );
  modport slave (
    output start, mem_ins, exec_done, br_taken, br_tgt, step,
    input  pc, ins, ins_valid, halted
  );
`else
  modport master (
    input  start, mem_ins, exec_done, br_taken, br_tgt,
    output pc, ins, ins_valid, halted
  );
  modport slave (
    output start, mem_ins, exec_done, br_taken, br_tgt,
    input  pc, ins, ins_valid, halted
  );
`endif

endinterface

// File: rtl/pc_reg.sv
// Program counter register with asynchronous active-low reset.
//   clk_i      : clock
//   rst_ni     : async active-low reset, loads ResetVal
//   load_i     : load load_val_i (has priority over inc_i)
//   load_val_i : value to load (branch target or reset PC)
//   inc_i      : advance by one, wrapping modulo 2**PcW
//   pc_o       : current PC
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PcW-1:0] ResetVal = ResetPc
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [PcW-1:0] load_val_i,
  input  logic           inc_i,
  output logic [PcW-1:0] pc_o
);

  logic [PcW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PcW'(1);  // natural wrap 15 -> 0
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetVal;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer. Owns the PC, latches the instruction word from
// ins_mem and hands it to the datapath with an ins_valid/exec_done handshake.
// Handles sequential advance, taken branches and halt.
//   clk_i  : clock, rising edge
//   rst_ni : async active-low reset
//   bus    : fetch_seq_if.master (start, pc, mem_ins, ins, ins_valid,
//            exec_done, br_taken, br_tgt, halted[, step])
// Optional feature: define SINGLE_STEP_EN to add bus.step; FETCH then only
// completes in a cycle with step=1, re-sampling mem_ins while it waits.
module fetch_seq
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  fetch_seq_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [InsW-1:0] ins_q, ins_d;
  logic            ins_valid_q, ins_valid_d;
  logic            halted_q, halted_d;

  logic            pc_load;
  logic [PcW-1:0]  pc_load_val;
  logic            pc_inc;
  logic [PcW-1:0]  pc;
  logic            fetch_go;

`ifdef SINGLE_STEP_EN
  assign fetch_go = bus.step;
`else
  assign fetch_go = 1'b1;
`endif

  pc_reg #(
    .ResetVal (ResetPc)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    halted_d    = halted_q;
    pc_load     = 1'b0;
    pc_load_val = ResetPc;
    pc_inc      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // PC already sits at the reset value here.
        if (bus.start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        ins_d = bus.mem_ins;
        if (fetch_go) begin
          if (is_halt(bus.mem_ins)) begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end else begin
            ins_valid_d = 1'b1;
            state_d     = StExec;
          end
        end
      end
      StExec: begin
        if (bus.exec_done) begin
          ins_valid_d = 1'b0;
          if (bus.br_taken) begin
            pc_load     = 1'b1;
            pc_load_val = bus.br_tgt;
          end else begin
            pc_inc = 1'b1;
          end
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (bus.start) begin
          pc_load     = 1'b1;
          pc_load_val = ResetPc;
          halted_d    = 1'b0;
          state_d     = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.pc        = pc;
  assign bus.ins       = ins_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq. A behavioural instruction memory feeds
// mem_ins; expected (pc, ins) pairs are queued when an issue is triggered and
// popped when ins_valid rises.
module tb_fetch_seq;
  import cpu_pkg::*;

  typedef struct packed {
    logic [PcW-1:0]  pc;
    logic [InsW-1:0] ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_seq_if bus ();

  fetch_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [InsW-1:0] mem [16];
  assign bus.mem_ins = mem[bus.pc];

  exp_t           sb[$];
  int             tests_run    = 0;
  int             tests_failed = 0;
  logic [PcW-1:0] model_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (bus.ins_valid) break;
    end
  endtask

  // Pulse exec_done in EXEC, queue the expected next issue, wait for it.
  task automatic done_and_wait(input logic taken, input logic [PcW-1:0] tgt,
                               output int n, output logic v_after, output exp_t e);
    int m;
    logic [PcW-1:0] nxt;
    nxt = taken ? tgt : model_pc + PcW'(1);
    model_pc = nxt;
    sb.push_back('{pc: nxt, ins: mem[nxt]});
    bus.exec_done = 1'b1;
    bus.br_taken  = taken;
    bus.br_tgt    = tgt;
    tick();
    bus.exec_done = 1'b0;
    bus.br_taken  = 1'b0;
    v_after = bus.ins_valid;
    n = 1;
    if (!bus.ins_valid) begin
      wait_valid(m);
      n += m;
    end
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.exec_done = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_tgt    = '0;
`ifdef SINGLE_STEP_EN
    bus.step      = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    tests_run += 4;
    if (bus.pc !== 4'd0) begin
      tests_failed++; $display("FAIL reset_pc: got %h expected 0", bus.pc);
    end
    if (bus.ins !== 9'h000) begin
      tests_failed++; $display("FAIL reset_ins: got %h expected 000", bus.ins);
    end
    if (bus.ins_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.ins_valid);
    end
    if (bus.halted !== 1'b0) begin
      tests_failed++; $display("FAIL reset_halted: got %b expected 0", bus.halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.ins_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_hold: got %b expected 0", bus.ins_valid);
    end
    model_pc = ResetPc;
  endtask

  task automatic test_start();
    int   n, m;
    exp_t e;
    sb.push_back('{pc: ResetPc, ins: mem[ResetPc]});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    if (!bus.ins_valid) begin
      wait_valid(m);
      n += m;
    end
    e = sb.pop_front();
    tests_run += 3;
    if (n !== 2) begin
      tests_failed++; $display("FAIL start_latency: got %0d expected 2", n);
    end
    if (bus.pc !== e.pc) begin
      tests_failed++; $display("FAIL start_pc: got %h expected %h", bus.pc, e.pc);
    end
    if (bus.ins !== e.ins) begin
      tests_failed++; $display("FAIL start_ins: got %h expected %h", bus.ins, e.ins);
    end
  endtask

  task automatic test_sequential();
    int   n;
    logic v;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      done_and_wait(1'b0, 4'd0, n, v, e);
      tests_run += 4;
      if (v !== 1'b0) begin
        tests_failed++; $display("FAIL seq_drop[%0d]: got %b expected 0", i, v);
      end
      if (n !== 2) begin
        tests_failed++; $display("FAIL seq_latency[%0d]: got %0d expected 2", i, n);
      end
      if (bus.pc !== e.pc) begin
        tests_failed++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc, e.pc);
      end
      if (bus.ins !== e.ins) begin
        tests_failed++; $display("FAIL seq_ins[%0d]: got %h expected %h", i, bus.ins, e.ins);
      end
    end
  endtask

  task automatic test_branch();
    logic [PcW-1:0] tgts [3];
    int   n;
    logic v;
    exp_t e;
    tgts[0] = 4'd2;
    tgts[1] = 4'd1;
    tgts[2] = 4'd1;  // branch to self
    for (int i = 0; i < 3; i++) begin
      done_and_wait(1'b1, tgts[i], n, v, e);
      tests_run += 3;
      if (n !== 2) begin
        tests_failed++; $display("FAIL br_latency[%0d]: got %0d expected 2", i, n);
      end
      if (bus.pc !== e.pc) begin
        tests_failed++; $display("FAIL br_pc[%0d]: got %h expected %h", i, bus.pc, e.pc);
      end
      if (bus.ins !== e.ins) begin
        tests_failed++; $display("FAIL br_ins[%0d]: got %h expected %h", i, bus.ins, e.ins);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    bus.start    = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_tgt   = 4'd7;
    repeat (3) tick();
    bus.start    = 1'b0;
    bus.br_taken = 1'b0;
    tests_run += 3;
    if (bus.ins_valid !== 1'b1) begin
      tests_failed++; $display("FAIL ign_valid: got %b expected 1", bus.ins_valid);
    end
    if (bus.pc !== model_pc) begin
      tests_failed++; $display("FAIL ign_pc: got %h expected %h", bus.pc, model_pc);
    end
    if (bus.ins !== mem[model_pc]) begin
      tests_failed++; $display("FAIL ign_ins: got %h expected %h", bus.ins, mem[model_pc]);
    end
  endtask

  task automatic test_wrap();
    int   n;
    logic v;
    exp_t e;
    done_and_wait(1'b1, 4'd15, n, v, e);
    tests_run++;
    if (bus.pc !== e.pc) begin
      tests_failed++; $display("FAIL wrap_pre_pc: got %h expected %h", bus.pc, e.pc);
    end
    done_and_wait(1'b0, 4'd0, n, v, e);
    tests_run += 3;
    if (bus.pc !== 4'd0 || e.pc !== 4'd0) begin
      tests_failed++; $display("FAIL wrap_pc: got %h expected 0", bus.pc);
    end
    if (bus.ins !== e.ins) begin
      tests_failed++; $display("FAIL wrap_ins: got %h expected %h", bus.ins, e.ins);
    end
    if (bus.halted !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_halted: got %b expected 0", bus.halted);
    end
  endtask

  task automatic test_halt();
    int   n, m;
    logic v;
    exp_t e;
    logic [InsW-1:0] saved;
    saved  = mem[3];
    mem[3] = HaltIns;
    // model_pc is 0 here; advance to PC=2.
    done_and_wait(1'b0, 4'd0, n, v, e);
    done_and_wait(1'b0, 4'd0, n, v, e);
    tests_run++;
    if (bus.pc !== 4'd2) begin
      tests_failed++; $display("FAIL halt_pre_pc: got %h expected 2", bus.pc);
    end
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    tick();
    tests_run += 4;
    if (bus.halted !== 1'b1) begin
      tests_failed++; $display("FAIL halt_flag: got %b expected 1", bus.halted);
    end
    if (bus.ins_valid !== 1'b0) begin
      tests_failed++; $display("FAIL halt_valid: got %b expected 0", bus.ins_valid);
    end
    if (bus.pc !== 4'd3) begin
      tests_failed++; $display("FAIL halt_pc: got %h expected 3", bus.pc);
    end
    if (bus.ins !== HaltIns) begin
      tests_failed++; $display("FAIL halt_ins: got %h expected %h", bus.ins, HaltIns);
    end
    // exec_done outside EXEC must not move anything.
    bus.exec_done = 1'b1;
    repeat (2) tick();
    bus.exec_done = 1'b0;
    tests_run++;
    if (bus.halted !== 1'b1 || bus.pc !== 4'd3) begin
      tests_failed++;
      $display("FAIL halt_hold: got halted=%b pc=%h expected halted=1 pc=3", bus.halted, bus.pc);
    end
    sb.push_back('{pc: ResetPc, ins: mem[ResetPc]});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run += 2;
    if (bus.halted !== 1'b0) begin
      tests_failed++; $display("FAIL restart_halted: got %b expected 0", bus.halted);
    end
    if (bus.pc !== ResetPc) begin
      tests_failed++; $display("FAIL restart_pc: got %h expected %h", bus.pc, ResetPc);
    end
    n = 1;
    if (!bus.ins_valid) begin
      wait_valid(m);
      n += m;
    end
    e = sb.pop_front();
    tests_run += 2;
    if (n !== 2) begin
      tests_failed++; $display("FAIL restart_latency: got %0d expected 2", n);
    end
    if (bus.ins !== e.ins) begin
      tests_failed++; $display("FAIL restart_ins: got %h expected %h", bus.ins, e.ins);
    end
    mem[3]   = saved;
    model_pc = ResetPc;
  endtask

  task automatic test_reset_mid_exec();
    int   n;
    logic v;
    exp_t e;
    done_and_wait(1'b0, 4'd0, n, v, e);  // now at PC=1 in EXEC
    bus.exec_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run += 4;
    if (bus.pc !== 4'd0) begin
      tests_failed++; $display("FAIL mid_rst_pc: got %h expected 0", bus.pc);
    end
    if (bus.ins !== 9'h000) begin
      tests_failed++; $display("FAIL mid_rst_ins: got %h expected 000", bus.ins);
    end
    if (bus.ins_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_rst_valid: got %b expected 0", bus.ins_valid);
    end
    if (bus.halted !== 1'b0) begin
      tests_failed++; $display("FAIL mid_rst_halted: got %b expected 0", bus.halted);
    end
    bus.exec_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.ins_valid !== 1'b0 || bus.pc !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_rst_idle: got valid=%b pc=%h expected valid=0 pc=0",
               bus.ins_valid, bus.pc);
    end
    model_pc = ResetPc;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    bus.step  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (bus.ins_valid !== 1'b0) begin
      tests_failed++; $display("FAIL step_hold: got %b expected 0", bus.ins_valid);
    end
    bus.step = 1'b1;
    tick();
    tests_run += 2;
    if (bus.ins_valid !== 1'b1) begin
      tests_failed++; $display("FAIL step_valid: got %b expected 1", bus.ins_valid);
    end
    if (bus.ins !== mem[ResetPc]) begin
      tests_failed++; $display("FAIL step_ins: got %h expected %h", bus.ins, mem[ResetPc]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 9'(16 + 3 * i);
    mem[0] = 9'h086;
    mem[1] = 9'h09D;
    test_reset();
    test_start();
    test_sequential();
    test_branch();
    test_ignored_inputs();
    test_wrap();
    test_halt();
    test_reset_mid_exec();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
